// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional build macro: IF_MISALIGN_CHECK_EN (misaligned-redirect reporting).
package if_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    KILL = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_KILL  = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_INC_VAL    = 32'd4;

`ifdef IF_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  // A target is only treated as misaligned when the check is built in.
  function automatic logic misaligned(input logic [1:0] pc_lo);
    return MISALIGN_EN & (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_stage_pc_gen.sv
// Fetch-PC and kill-PC registers with the next-PC select mux.
module if_pc_gen
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        res,
  input  pc_sel_e     pc_sel,
  input  logic        kill_load,
  input  logic [31:0] redir_pc,
  output logic [31:0] fetch_pc,
  output logic [31:0] kill_pc
);

  logic [31:0] fetch_pc_r;
  logic [31:0] kill_pc_r;
  logic [31:0] next_pc_s;

  // Next fetch address: hold, sequential (+4, wraps modulo 2^32), redirect or parked kill target.
  always_comb begin
    next_pc_s = fetch_pc_r;
    case (pc_sel)
      PC_HOLD:  next_pc_s = fetch_pc_r;
      PC_INC:   next_pc_s = fetch_pc_r + PC_INC_VAL;
      PC_REDIR: next_pc_s = redir_pc;
      PC_KILL:  next_pc_s = kill_pc_r;
      default:  next_pc_s = fetch_pc_r;
    endcase
  end

  // PC registers; kill_pc parks a redirect target while a stale response drains.
  always_ff @(posedge clk) begin
    if (!res) begin
      fetch_pc_r <= RESET_PC;
      kill_pc_r  <= RESET_PC;
    end else begin
      fetch_pc_r <= next_pc_s;
      if (kill_load) begin
        kill_pc_r <= redir_pc;
      end
    end
  end

  assign fetch_pc = fetch_pc_r;
  assign kill_pc  = kill_pc_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, presents instruction+PC to IF/ID.
// Optional build macro: IF_MISALIGN_CHECK_EN adds the fetch_misaligned output.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   PC_write,
  input  logic                   redirect,
  input  logic [31:0]            redirect_PC,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            PC_out,
  output logic [31:0]            instruction_out,
  output logic                   if_valid
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic                   fetch_misaligned
`endif
);

  state_e      state_r;
  state_e      next_s;
  pc_sel_e     pc_sel_s;
  logic        kill_load_s;
  logic        capture_s;
  logic        mis_hold_s;
  logic        leave_s;
  logic        nop_s;
  logic [31:0] fetch_pc_s;
  logic [31:0] kill_pc_s;
  logic [31:0] redir_pc_s;
  logic [31:0] target_s;
  logic        req_r;
  logic        valid_r;
  logic [31:0] pc_out_r;
  logic [31:0] instr_r;

  // Without the misalign check the low target bits are simply dropped.
  assign redir_pc_s = MISALIGN_EN ? redirect_PC : {redirect_PC[31:2], 2'b00};
  // Address a drained KILL resumes at; a same-cycle redirect overrides the parked one.
  assign target_s   = ((state_r == KILL) && !redirect) ? kill_pc_s : redir_pc_s;

  if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk       (clk),
    .res       (res),
    .pc_sel    (pc_sel_s),
    .kill_load (kill_load_s),
    .redir_pc  (redir_pc_s),
    .fetch_pc  (fetch_pc_s),
    .kill_pc   (kill_pc_s)
  );

  // Next-state and datapath-control decode; redirect always outranks the stall/transfer path.
  always_comb begin
    next_s      = state_r;
    pc_sel_s    = PC_HOLD;
    kill_load_s = 1'b0;
    capture_s   = 1'b0;
    mis_hold_s  = 1'b0;
    leave_s     = 1'b0;
    nop_s       = 1'b0;
    case (state_r)
      IDLE: next_s = REQ;
      REQ: begin
        if (redirect && imem.imem_gnt) begin
          kill_load_s = 1'b1;
          next_s      = KILL;
        end else if (redirect) begin
          pc_sel_s = PC_REDIR;
          if (misaligned(target_s[1:0])) begin
            mis_hold_s = 1'b1;
            next_s     = HOLD;
          end else begin
            next_s = REQ;
          end
        end else if (imem.imem_gnt) begin
          next_s = WAIT;
        end else begin
          next_s = REQ;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid && redirect) begin
          pc_sel_s = PC_REDIR;
          if (misaligned(target_s[1:0])) begin
            mis_hold_s = 1'b1;
            next_s     = HOLD;
          end else begin
            next_s = REQ;
          end
        end else if (imem.imem_rvalid) begin
          capture_s = 1'b1;
          next_s    = HOLD;
        end else if (redirect) begin
          kill_load_s = 1'b1;
          next_s      = KILL;
        end else begin
          next_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_sel_s = PC_REDIR;
          leave_s  = 1'b1;
          nop_s    = 1'b1;
          if (misaligned(target_s[1:0])) begin
            mis_hold_s = 1'b1;
            next_s     = HOLD;
          end else begin
            next_s = REQ;
          end
        end else if (PC_write) begin
          pc_sel_s = PC_INC;
          leave_s  = 1'b1;
          next_s   = REQ;
        end else begin
          next_s = HOLD;
        end
      end
      KILL: begin
        if (imem.imem_rvalid) begin
          pc_sel_s = redirect ? PC_REDIR : PC_KILL;
          if (misaligned(target_s[1:0])) begin
            mis_hold_s = 1'b1;
            next_s     = HOLD;
          end else begin
            next_s = REQ;
          end
        end else if (redirect) begin
          kill_load_s = 1'b1;
          next_s      = KILL;
        end else begin
          next_s = KILL;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // FSM state plus registered request and IF/ID-facing outputs.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_r  <= IDLE;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      pc_out_r <= RESET_PC;
      instr_r  <= NOP_INSTR;
    end else begin
      state_r <= next_s;
      req_r   <= (next_s == REQ);
      if (capture_s) begin
        instr_r  <= imem.imem_rdata;
        pc_out_r <= fetch_pc_s;
        valid_r  <= 1'b1;
      end else if (mis_hold_s) begin
        instr_r  <= NOP_INSTR;
        pc_out_r <= target_s;
        valid_r  <= 1'b1;
      end else if (leave_s) begin
        valid_r <= 1'b0;
        if (nop_s) begin
          instr_r <= NOP_INSTR;
        end
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic mis_r;

  // Misalign flag: set on entering HOLD for a bad target, cleared on transfer or any new redirect.
  always_ff @(posedge clk) begin
    if (!res) begin
      mis_r <= 1'b0;
    end else if (mis_hold_s) begin
      mis_r <= 1'b1;
    end else if (leave_s || capture_s) begin
      mis_r <= 1'b0;
    end
  end

  assign fetch_misaligned = mis_r;
`endif

  assign imem.imem_req   = req_r;
  assign imem.imem_addr  = fetch_pc_s;
  assign PC_out          = pc_out_r;
  assign instruction_out = instr_r;
  assign if_valid        = valid_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized run
// against a transaction-level model (expected next PC, deterministic memory contents).
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        res;
  logic        PC_write;
  logic        redirect;
  logic [31:0] redirect_PC;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        if_valid;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif
  int checks = 0;
  int passed = 0;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk             (clk),
    .res             (res),
    .PC_write        (PC_write),
    .redirect        (redirect),
    .redirect_PC     (redirect_PC),
    .imem            (bus),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .if_valid        (if_valid)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
  endfunction

  task automatic test_reset();
    res = 1'b0; PC_write = 1'b0; redirect = 1'b0; redirect_PC = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    tick(); tick();
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else passed++;
    checks++; if (PC_out !== 32'h0) $display("FAIL reset_pc: got %h want 0", PC_out); else passed++;
    checks++; if (instruction_out !== NOP) $display("FAIL reset_instr: got %h want %h", instruction_out, NOP); else passed++;
  endtask

  task automatic test_basic();
    res = 1'b1; tick();
    checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) $display("FAIL basic_req0: got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else passed++;
    bus.imem_gnt = 1'b1; tick();
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL basic_wait_req: got %b want 0", bus.imem_req); else passed++;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0010_0093; tick();
    checks++; if ({if_valid, PC_out, instruction_out} !== {1'b1, 32'h0, 32'h0010_0093})
      $display("FAIL basic_present: got %b/%h/%h want 1/0/00100093", if_valid, PC_out, instruction_out); else passed++;
    bus.imem_rvalid = 1'b0; PC_write = 1'b1; tick();
    checks++; if (if_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", if_valid); else passed++;
    checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) $display("FAIL basic_next_addr: got %b/%h want 1/4", bus.imem_req, bus.imem_addr); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = $urandom;
    bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = w; tick();
    bus.imem_rvalid = 1'b0; PC_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({if_valid, bus.imem_req, PC_out, instruction_out} !== {1'b1, 1'b0, 32'h4, w})
        $display("FAIL stall_hold%0d: got %b/%b/%h/%h want 1/0/4/%h", i, if_valid, bus.imem_req, PC_out, instruction_out, w); else passed++;
    end
    PC_write = 1'b1; tick();
    checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) $display("FAIL stall_next_addr: got %b/%h want 1/8", bus.imem_req, bus.imem_addr); else passed++;
  endtask

  task automatic test_redirect_wait();
    bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; redirect = 1'b1; redirect_PC = 32'h0000_0100; tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0BAD; end
      checks++; if (if_valid !== 1'b0) $display("FAIL rdw_valid%0d: got %b want 0", i, if_valid); else passed++;
      tick();
    end
    bus.imem_rvalid = 1'b0;
    checks++; if ({if_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL rdw_next: got %b/%b/%h want 0/1/100", if_valid, bus.imem_req, bus.imem_addr); else passed++;
    tick();
    checks++; if (if_valid !== 1'b0) $display("FAIL rdw_no_stale: got %b want 0", if_valid); else passed++;
  endtask

  task automatic test_redirect_hold();
    bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5678; tick();
    checks++; if ({if_valid, PC_out} !== {1'b1, 32'h100}) $display("FAIL rdh_present: got %b/%h want 1/100", if_valid, PC_out); else passed++;
    bus.imem_rvalid = 1'b0; PC_write = 1'b1; redirect = 1'b1; redirect_PC = 32'h0000_0200; tick();
    redirect = 1'b0;
    checks++; if ({if_valid, instruction_out} !== {1'b0, NOP}) $display("FAIL rdh_drop: got %b/%h want 0/%h", if_valid, instruction_out, NOP); else passed++;
    checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) $display("FAIL rdh_addr: got %b/%h want 1/200", bus.imem_req, bus.imem_addr); else passed++;
  endtask

  task automatic test_wrap_reset();
    redirect = 1'b1; redirect_PC = 32'hFFFF_FFFC; tick();
    redirect = 1'b0;
    checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_req: got %b/%h want 1/fffffffc", bus.imem_req, bus.imem_addr); else passed++;
    bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0073; tick();
    bus.imem_rvalid = 1'b0;
    checks++; if ({if_valid, PC_out} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_present: got %b/%h want 1/fffffffc", if_valid, PC_out); else passed++;
    PC_write = 1'b1; tick();
    checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_next: got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else passed++;
    bus.imem_gnt = 1'b1; tick();
    bus.imem_gnt = 1'b0; res = 1'b0; tick();
    checks++; if ({bus.imem_req, if_valid, PC_out, instruction_out} !== {1'b0, 1'b0, 32'h0, NOP})
      $display("FAIL midreset: got %b/%b/%h/%h want 0/0/0/%h", bus.imem_req, if_valid, PC_out, instruction_out, NOP); else passed++;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; tick();
    res = 1'b1; tick();
    bus.imem_rvalid = 1'b0;
    checks++; if ({if_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL late_rvalid: got %b/%b/%h want 0/1/0", if_valid, bus.imem_req, bus.imem_addr); else passed++;
    tick();
    checks++; if (if_valid !== 1'b0) $display("FAIL late_rvalid_hold: got %b want 0", if_valid); else passed++;
  endtask

`ifdef IF_MISALIGN_CHECK_EN
  task automatic test_misalign();
    res = 1'b0; redirect = 1'b0; PC_write = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; tick();
    res = 1'b1; tick();
    redirect = 1'b1; redirect_PC = 32'h0000_0102; tick();
    redirect = 1'b0;
    checks++; if ({bus.imem_req, fetch_misaligned, if_valid, PC_out, instruction_out} !== {1'b0, 1'b1, 1'b1, 32'h102, NOP})
      $display("FAIL misalign: got %b/%b/%b/%h/%h want 0/1/1/102/%h", bus.imem_req, fetch_misaligned, if_valid, PC_out, instruction_out, NOP); else passed++;
    PC_write = 1'b1; tick();
    checks++; if ({fetch_misaligned, if_valid} !== 2'b00) $display("FAIL misalign_clear: got %b/%b want 0/0", fetch_misaligned, if_valid); else passed++;
  endtask
`endif

  task automatic test_random();
    logic [31:0] pend;
    logic [31:0] out_addr;
    logic        outstanding;
    int          cnt;
    int          shown;
    int          grants;
    res = 1'b0; PC_write = 1'b0; redirect = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    tick(); tick();
    res = 1'b1;
    pend = 32'h0; out_addr = 32'h0; outstanding = 1'b0; cnt = 0; shown = 0; grants = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (if_valid) begin
        shown++;
        checks++; if (PC_out !== pend) $display("FAIL rand_pc c=%0d: got %h want %h", c, PC_out, pend); else passed++;
        checks++; if (instruction_out !== mem_word(pend)) $display("FAIL rand_instr c=%0d: got %h want %h", c, instruction_out, mem_word(pend)); else passed++;
      end
      if (bus.imem_req) begin
        checks++; if ({outstanding, if_valid} !== 2'b00) $display("FAIL rand_req_excl c=%0d: got %b want 00", c, {outstanding, if_valid}); else passed++;
      end
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (outstanding) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(out_addr);
          outstanding     = 1'b0;
        end
      end
      bus.imem_gnt = bus.imem_req && !outstanding && ($urandom_range(0, 3) != 0);
      redirect     = (c >= 4) && ($urandom_range(0, 11) == 0);
      redirect_PC  = $urandom;
`ifdef IF_MISALIGN_CHECK_EN
      redirect_PC[1:0] = 2'b00;
`endif
      PC_write = ($urandom_range(0, 2) != 0);
      if (bus.imem_gnt && !redirect) begin
        checks++; if (bus.imem_addr !== pend) $display("FAIL rand_addr c=%0d: got %h want %h", c, bus.imem_addr, pend); else passed++;
      end
      if (bus.imem_gnt) begin
        outstanding = 1'b1;
        cnt         = $urandom_range(1, 3);
        out_addr    = bus.imem_addr;
        grants++;
      end
      if (redirect) pend = {redirect_PC[31:2], 2'b00};
      else if (if_valid && PC_write) pend = pend + 32'd4;
    end
    checks++; if (shown < 50) $display("FAIL rand_progress: got %0d presented cycles want >=50", shown); else passed++;
    checks++; if (grants < 50) $display("FAIL rand_grants: got %0d grants want >=50", grants); else passed++;
    redirect = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap_reset();
    test_random();
`ifdef IF_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
